// File: rtl/modulator_pipelined.sv
// modulator_pipelined
// Amplitude modulator placed between the duty/phase generator and the PWM
// stage. It keeps a modulation sample index that advances on reference-clock
// ticks through a programmable divider. It reads samples from an external
// synchronous memory and scales every transducer duty by the current sample.
//
// Ports
//   CLK, RST        system clock; synchronous active-high reset
//   REF_CLK_TICK    one-cycle reference tick that drives the divider
//   MOD_CLK_CYCLE   last valid sample index (sequence length - 1)
//   MOD_CLK_DIV     ticks per sample minus one
//   MOD_EN          1 = modulate, 0 = pass DUTY straight through
//   ONE_SHOT        1 = stop at the last sample and raise DONE, 0 = loop
//   ARM, SYNC       a rising edge on ARM arms a one-time load of
//                   INIT_IDX/INIT_DIV on the next SYNC
//   MEM_ADDR        sample memory read address (equals MOD_IDX)
//   MEM_DATA        sample memory data, valid MEM_LATENCY cycles after MEM_ADDR
//   DUTY            per-channel unmodulated duties
//   DUTY_MODULATED  per-channel registered result
//   MOD_IDX, ARMED, DONE  status
module modulator_pipelined #(
  parameter int TRANS_NUM   = 249,
  parameter int DUTY_WIDTH  = 8,
  parameter int MOD_WIDTH   = 8,
  parameter int IDX_WIDTH   = 16,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REF_CLK_TICK,
  input  logic [IDX_WIDTH-1:0]  MOD_CLK_CYCLE,
  input  logic [15:0]           MOD_CLK_DIV,
  input  logic                  MOD_EN,
  input  logic                  ONE_SHOT,
  input  logic                  ARM,
  input  logic                  SYNC,
  input  logic [IDX_WIDTH-1:0]  INIT_IDX,
  input  logic [15:0]           INIT_DIV,
  output logic [IDX_WIDTH-1:0]  MEM_ADDR,
  input  logic [MOD_WIDTH-1:0]  MEM_DATA,
  input  logic [DUTY_WIDTH-1:0] DUTY [TRANS_NUM],
  output logic [DUTY_WIDTH-1:0] DUTY_MODULATED [TRANS_NUM],
  output logic [IDX_WIDTH-1:0]  MOD_IDX,
  output logic                  ARMED,
  output logic                  DONE
);

  localparam int PROD_WIDTH = DUTY_WIDTH + MOD_WIDTH + 1;

  // The read latency is absorbed by the memory itself: data arriving on
  // MEM_DATA is used in the cycle it appears. A zero latency would make the
  // address-to-data path combinational, which this block does not support.
  if (MEM_LATENCY < 1) begin : g_invalid_mem_latency
    $error("modulator_pipelined: MEM_LATENCY must be at least 1");
  end

  logic [IDX_WIDTH-1:0]  idx;
  logic [15:0]           div;
  logic                  armed;
  logic                  done;
  logic                  arm_d;
  logic                  arm_edge;
  logic                  sync_load;
  logic [IDX_WIDTH-1:0]  load_idx;
  logic [15:0]           load_div;

  logic [MOD_WIDTH:0]    sample_plus_one;
  logic [PROD_WIDTH-1:0] prod   [TRANS_NUM];
  logic [DUTY_WIDTH-1:0] scaled [TRANS_NUM];
  logic                  unused_prod_bits;

  assign arm_edge  = ARM & ~arm_d;
  assign sync_load = armed & SYNC;

  // Out-of-range load values are clamped to zero, so a resync can never start
  // the counter outside the programmed sequence.
  assign load_idx = (INIT_IDX > MOD_CLK_CYCLE) ? '0 : INIT_IDX;
  assign load_div = (INIT_DIV > MOD_CLK_DIV) ? '0 : INIT_DIV;

  // Index/divider counter with resync load and one-shot stop. An armed SYNC
  // takes priority over a tick arriving in the same cycle. A fresh ARM edge
  // that coincides with the load re-arms, so the next SYNC loads again.
  // Outside a load the counters compare for equality only. If the limits are
  // lowered below the current count, the counter runs on to the all-ones
  // wrap before it returns to the sequence.
  always_ff @(posedge CLK) begin
    if (RST) begin
      idx   <= '0;
      div   <= '0;
      armed <= 1'b0;
      done  <= 1'b0;
      arm_d <= 1'b0;
    end else begin
      arm_d <= ARM;
      if (sync_load) begin
        idx   <= load_idx;
        div   <= load_div;
        done  <= 1'b0;
        armed <= arm_edge;
      end else begin
        if (arm_edge) begin
          armed <= 1'b1;
        end
        if (REF_CLK_TICK && !done) begin
          if (div == MOD_CLK_DIV) begin
            div <= '0;
            if (idx == MOD_CLK_CYCLE) begin
              if (ONE_SHOT) begin
                done <= 1'b1;
              end else begin
                idx <= '0;
              end
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            div <= div + 1'b1;
          end
        end
      end
    end
  end

  assign MEM_ADDR = idx;
  assign MOD_IDX  = idx;
  assign ARMED    = armed;
  assign DONE     = done;

  // The scale factor is (sample + 1) / 2^MOD_WIDTH. An all-ones sample
  // therefore reproduces the duty exactly. The product always fits below its
  // top bit, so no saturation is needed. The low fraction bits and the spare
  // top bit are dropped; they are folded into a sink signal here.
  assign sample_plus_one = {1'b0, MEM_DATA} + {{MOD_WIDTH{1'b0}}, 1'b1};

  always_comb begin
    unused_prod_bits = 1'b0;
    for (int i = 0; i < TRANS_NUM; i++) begin
      prod[i]   = PROD_WIDTH'(DUTY[i]) * PROD_WIDTH'(sample_plus_one);
      scaled[i] = prod[i][PROD_WIDTH-2:MOD_WIDTH];
      unused_prod_bits = unused_prod_bits ^ prod[i][PROD_WIDTH-1]
                         ^ (^prod[i][MOD_WIDTH-1:0]);
    end
  end

  // Output register. Bypass goes through the same register, so the latency
  // from DUTY to the output is one cycle in both modes.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < TRANS_NUM; i++) begin
      if (RST) begin
        DUTY_MODULATED[i] <= '0;
      end else if (MOD_EN) begin
        DUTY_MODULATED[i] <= scaled[i];
      end else begin
        DUTY_MODULATED[i] <= DUTY[i];
      end
    end
  end

endmodule

// File: tb/tb_modulator_pipelined.sv
// tb_modulator_pipelined
// Directed bench for modulator_pipelined. The main instance uses 8-bit duties
// and samples, four channels, and a 2-cycle sample memory. A second instance
// uses 10-bit duties, 6-bit samples and a 1-cycle memory. The stimulus process
// pushes hand-computed expectations, each tagged with the cycle it is due. A
// separate monitor pops and compares them on the falling edge of that cycle.
module tb_modulator_pipelined;

  localparam int S_IDX   = 0;
  localparam int S_DM0   = 1;
  localparam int S_DM3   = 2;
  localparam int S_ARMED = 3;
  localparam int S_DONE  = 4;
  localparam int S_SW0   = 5;
  localparam int S_SW3   = 6;

  typedef struct {
    int          cycle;
    int          sel;
    logic [31:0] value;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic CLK;

  // main instance signals
  logic        rst, tick, mod_en, one_shot, arm, sync;
  logic [15:0] cycle_len, clk_div, init_idx, init_div;
  logic [15:0] mem_addr0, mod_idx0;
  logic [7:0]  mem_data0, mem_s1;
  logic [7:0]  duty0 [4];
  logic [7:0]  dm0 [4];
  logic        armed0, done0;
  logic [7:0]  mem0 [8] = '{8'd255, 8'd127, 8'd0, 8'd63, 8'd0, 8'd0, 8'd0, 8'd0};

  // sweep instance signals
  logic        rst_sw, tick_sw;
  logic [15:0] cycle_sw, div_sw, zero16;
  logic        en_sw, low_sw;
  logic [15:0] mem_addr1, mod_idx1;
  logic [5:0]  mem_data1;
  logic [9:0]  duty1 [4];
  logic [9:0]  dm1 [4];
  logic        armed1, done1;
  logic [5:0]  mem1 [4] = '{6'd63, 6'd31, 6'd0, 6'd47};

  int idx_tab [11] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0, 1};
  int out_tab [11] = '{200, 200, 200, 200, 100, 100, 0, 0, 50, 50, 200};
  int sw_tab  [7]  = '{1023, 1023, 511, 15, 767, 1023, 511};

  modulator_pipelined #(
    .TRANS_NUM(4), .DUTY_WIDTH(8), .MOD_WIDTH(8), .IDX_WIDTH(16), .MEM_LATENCY(2)
  ) dut (
    .CLK(CLK), .RST(rst), .REF_CLK_TICK(tick), .MOD_CLK_CYCLE(cycle_len),
    .MOD_CLK_DIV(clk_div), .MOD_EN(mod_en), .ONE_SHOT(one_shot), .ARM(arm),
    .SYNC(sync), .INIT_IDX(init_idx), .INIT_DIV(init_div), .MEM_ADDR(mem_addr0),
    .MEM_DATA(mem_data0), .DUTY(duty0), .DUTY_MODULATED(dm0), .MOD_IDX(mod_idx0),
    .ARMED(armed0), .DONE(done0)
  );

  modulator_pipelined #(
    .TRANS_NUM(4), .DUTY_WIDTH(10), .MOD_WIDTH(6), .IDX_WIDTH(16), .MEM_LATENCY(1)
  ) dut_sweep (
    .CLK(CLK), .RST(rst_sw), .REF_CLK_TICK(tick_sw), .MOD_CLK_CYCLE(cycle_sw),
    .MOD_CLK_DIV(div_sw), .MOD_EN(en_sw), .ONE_SHOT(low_sw), .ARM(low_sw),
    .SYNC(low_sw), .INIT_IDX(zero16), .INIT_DIV(zero16), .MEM_ADDR(mem_addr1),
    .MEM_DATA(mem_data1), .DUTY(duty1), .DUTY_MODULATED(dm1), .MOD_IDX(mod_idx1),
    .ARMED(armed1), .DONE(done1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Sample memories: two register stages for the main instance, one for the sweep.
  always @(posedge CLK) begin
    mem_s1    <= mem0[mem_addr0[2:0]];
    mem_data0 <= mem_s1;
    mem_data1 <= mem1[mem_addr1[1:0]];
  end

  task automatic push_expect(input int at, input int sel, input logic [31:0] value,
                             input string name);
    exp_t e;
    e.cycle = at;
    e.sel   = sel;
    e.value = value;
    e.name  = name;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [31:0] actual;
    case (e.sel)
      S_IDX:   actual = 32'(mod_idx0);
      S_DM0:   actual = 32'(dm0[0]);
      S_DM3:   actual = 32'(dm0[3]);
      S_ARMED: actual = 32'(armed0);
      S_DONE:  actual = 32'(done0);
      S_SW0:   actual = 32'(dm1[0]);
      S_SW3:   actual = 32'(dm1[3]);
      default: actual = 'x;
    endcase
    n_checks++;
    if (actual !== e.value) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d",
               e.name, e.cycle, actual, e.value);
    end
  endtask

  // Monitor: compare every expectation that is due in this cycle.
  always @(negedge CLK) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cycle == cyc) begin
        checkOutput(sb[i]);
        sb.delete(i);
      end else if (sb[i].cycle < cyc) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s missed: got no check, expected cycle %0d", sb[i].name,
                 sb[i].cycle);
        sb.delete(i);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic t, input logic en,
                               input logic os, input logic a, input logic s,
                               input logic [15:0] ii, input logic [15:0] id,
                               input logic [15:0] cl, input logic [15:0] dv);
    rst = r; tick = t; mod_en = en; one_shot = os; arm = a; sync = s;
    init_idx = ii; init_div = id; cycle_len = cl; clk_div = dv;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      duty0[i] = 8'd200;
      duty1[i] = 10'd1023;
    end
    rst_sw = 1'b1; tick_sw = 1'b0; cycle_sw = 16'd3; div_sw = 16'd0;
    zero16 = 16'd0; en_sw = 1'b1; low_sw = 1'b0;
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 16'd3, 16'd1);
    step(3);

    // reset state, then basic loop and arithmetic (cycle 3)
    push_expect(cyc, S_IDX,   0, "reset_idx");
    push_expect(cyc, S_ARMED, 0, "reset_armed");
    push_expect(cyc, S_DONE,  0, "reset_done");
    push_expect(cyc, S_DM0,   0, "reset_dm0");
    for (int d = 1; d < 11; d++) push_expect(cyc + d, S_IDX, idx_tab[d], "loop_idx");
    for (int d = 1; d < 12; d++) push_expect(cyc + d, S_DM0, out_tab[d-1], "arith_dm0");
    push_expect(cyc + 5, S_DM3, 100, "arith_dm3");
    for (int d = 1; d < 8; d++) push_expect(cyc + d, S_SW0, sw_tab[d-1], "sweep_dm0");
    push_expect(cyc + 3, S_SW3, 511, "sweep_dm3");
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 16'd3, 16'd1);
    rst_sw = 1'b0; tick_sw = 1'b1;
    step(11);

    // reset mid-run (cycle 14)
    push_expect(cyc + 1, S_IDX, 0, "midrst_idx");
    push_expect(cyc + 1, S_DM0, 0, "midrst_dm0");
    push_expect(cyc + 1, S_DM3, 0, "midrst_dm3");
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 16'd3, 16'd1);
    step(1);

    // one-shot playback (cycle 15)
    push_expect(cyc + 1, S_IDX, 1, "oneshot_idx1");
    push_expect(cyc + 2, S_IDX, 2, "oneshot_idx2");
    push_expect(cyc + 2, S_DONE, 0, "oneshot_notdone");
    push_expect(cyc + 3, S_IDX, 2, "oneshot_hold");
    push_expect(cyc + 3, S_DONE, 1, "oneshot_done");
    push_expect(cyc + 6, S_IDX, 2, "oneshot_frozen");
    applyStimulus(0, 1, 1, 1, 0, 0, 0, 0, 16'd2, 16'd0);
    step(6);
    push_expect(cyc + 1, S_ARMED, 1, "oneshot_armed");
    push_expect(cyc + 2, S_IDX, 1, "oneshot_reload_idx");
    push_expect(cyc + 2, S_DONE, 0, "oneshot_reload_done");
    push_expect(cyc + 2, S_ARMED, 0, "oneshot_reload_armed");
    push_expect(cyc + 3, S_IDX, 2, "oneshot_resume");
    push_expect(cyc + 4, S_DONE, 1, "oneshot_done_again");
    applyStimulus(0, 1, 1, 1, 1, 0, 0, 0, 16'd2, 16'd0);
    step(1);
    applyStimulus(0, 1, 1, 1, 1, 1, 16'd1, 0, 16'd2, 16'd0);
    step(1);
    applyStimulus(0, 1, 1, 1, 0, 0, 0, 0, 16'd2, 16'd0);
    step(2);

    // resync behaviour (reset at cycle 25)
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 16'd4, 16'd0);
    step(1);
    push_expect(cyc, S_DONE, 0, "resync_rst_done");
    push_expect(cyc + 1, S_IDX, 1, "unarmed_sync_idx");
    push_expect(cyc + 1, S_ARMED, 0, "unarmed_sync_armed");
    push_expect(cyc + 2, S_ARMED, 1, "arm_edge");
    push_expect(cyc + 3, S_ARMED, 1, "arm_holds");
    push_expect(cyc + 4, S_IDX, 4, "pre_wrap_idx");
    push_expect(cyc + 5, S_IDX, 0, "clamp_idx");
    push_expect(cyc + 5, S_ARMED, 0, "clamp_armed");
    push_expect(cyc + 6, S_IDX, 1, "post_clamp_idx");
    push_expect(cyc + 8, S_IDX, 1, "load_beats_tick");
    push_expect(cyc + 8, S_ARMED, 0, "load_disarms");
    push_expect(cyc + 11, S_IDX, 2, "edge_load_idx");
    push_expect(cyc + 11, S_ARMED, 1, "edge_load_rearm");
    push_expect(cyc + 12, S_ARMED, 0, "divclamp_armed");
    push_expect(cyc + 14, S_IDX, 0, "divclamp_wait");
    push_expect(cyc + 15, S_IDX, 1, "divclamp_advance");
    applyStimulus(0, 1, 1, 0, 0, 1, 16'd3, 0, 16'd4, 16'd0);
    step(1);
    applyStimulus(0, 1, 1, 0, 1, 0, 0, 0, 16'd4, 16'd0);
    step(1);
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 16'd4, 16'd0);
    step(2);
    applyStimulus(0, 1, 1, 0, 0, 1, 16'd9, 16'd0, 16'd4, 16'd0);
    step(1);
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 16'd4, 16'd0);
    step(1);
    applyStimulus(0, 1, 1, 0, 1, 0, 0, 0, 16'd4, 16'd0);
    step(1);
    applyStimulus(0, 1, 1, 0, 0, 1, 16'd1, 16'd0, 16'd4, 16'd0);
    step(1);
    applyStimulus(0, 1, 1, 0, 1, 0, 0, 0, 16'd4, 16'd0);
    step(1);
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 16'd4, 16'd0);
    step(1);
    applyStimulus(0, 1, 1, 0, 1, 1, 16'd2, 16'd0, 16'd4, 16'd0);
    step(1);
    applyStimulus(0, 1, 1, 0, 0, 1, 16'd0, 16'd7, 16'd4, 16'd2);
    step(1);
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 16'd4, 16'd2);
    step(3);

    // bypass, then back to modulation (cycle 41)
    for (int i = 0; i < 3; i++) duty0[i] = 8'd37;
    duty0[3] = 8'd250;
    push_expect(cyc + 1, S_DM0, 37, "bypass_dm0");
    push_expect(cyc + 2, S_DM3, 250, "bypass_dm3");
    push_expect(cyc + 3, S_IDX, 2, "bypass_counter");
    push_expect(cyc + 4, S_DM0, 18, "reenable_dm0");
    push_expect(cyc + 4, S_DM3, 125, "reenable_dm3");
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 16'd4, 16'd2);
    step(3);
    mod_en = 1'b1;

    for (int k = 0; k < 40 && sb.size() != 0; k++) step(1);
    while (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s timeout: got nothing, expected cycle %0d", sb[0].name,
               sb[0].cycle);
      void'(sb.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
